rca_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Splits a WIDTH-bit ripple-carry add/subtract into STAGES register-separated slices of WIDTH/STAGES bits. Carry ripples within a slice and is registered between slices.
- Valid/ready handshake on both sides with whole-pipe stall; adds subtract mode and signed-overflow flag.
- Sits in datapath units needing wide adds at full throughput without a long combinational carry chain.

---
 rtl/rca_pipe.sv | 112 +++++++++++
 tb/tb_rca_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor, WIDTH/STAGES bits per stage, valid/ready with global stall
module rca_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = WIDTH / STAGES;

   if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("rca_pipe: WIDTH must be a positive multiple of STAGES");
   end

   function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          c_in);
      logic [SW-1:0] r;
      logic          c;
      r = '0;
      c = c_in;
      for (int i = 0; i < SW; i++) begin
         r[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
      end
      return {c, r};
   endfunction

   logic adv;
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // Each stage carries only the operand bits still to be added and the sum bits already produced.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int RW = WIDTH - k * SW;

      logic [RW-1:0]         op_a, op_b;
      logic                  op_c, op_v;
      logic [SW:0]           sl;
      logic [(k+1)*SW-1:0]   s_d, s_q;
      logic                  v_q, c_q;

      if (k == 0) begin : g_src
         assign op_a = a;
         assign op_b = sub ? ~b : b;
         assign op_c = sub ? 1'b1 : cin;
         assign op_v = in_valid;
         assign s_d  = sl[SW-1:0];
      end else begin : g_src
         assign op_a = g_stage[k-1].g_reg.a_q;
         assign op_b = g_stage[k-1].g_reg.b_q;
         assign op_c = g_stage[k-1].c_q;
         assign op_v = g_stage[k-1].v_q;
         assign s_d  = {sl[SW-1:0], g_stage[k-1].s_q};
      end

      assign sl = slice_add(op_a[SW-1:0], op_b[SW-1:0], op_c);

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            s_q <= '0;
            c_q <= 1'b0;
         end else if (adv) begin
            v_q <= op_v;
            s_q <= s_d;
            c_q <= sl[SW];
         end
      end

      if (k < STAGES - 1) begin : g_reg
         logic [RW-SW-1:0] a_q, b_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= op_a[RW-1:SW];
               b_q <= op_b[RW-1:SW];
            end
         end
      end else begin : g_last
         logic ovf_q;
         // carry into the MSB is recovered as a ^ b_eff ^ sum at that bit
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= op_a[SW-1] ^ op_b[SW-1] ^ sl[SW-1] ^ sl[SW];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign s         = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - scoreboard bench for rca_pipe in 16/4, 8/1 and 8/8 configurations
module tb_rca_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready, m_cout, m_ovf;
   logic [15:0] m_a, m_b, m_s;
   logic        d1_in_valid, d1_in_ready, d1_cin, d1_sub, d1_out_valid, d1_out_ready, d1_cout, d1_ovf;
   logic [7:0]  d1_a, d1_b, d1_s;
   logic        d8_in_valid, d8_in_ready, d8_cin, d8_sub, d8_out_valid, d8_out_ready, d8_cout, d8_ovf;
   logic [7:0]  d8_a, d8_b, d8_s;

   int n_cmp = 0;
   int n_err = 0;
   logic [17:0] exp_q[$];
   logic [9:0]  exp8_q[$];

   rca_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .s(m_s), .cout(m_cout), .ovf(m_ovf));

   rca_pipe #(.WIDTH(8), .STAGES(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
      .a(d1_a), .b(d1_b), .cin(d1_cin), .sub(d1_sub),
      .out_valid(d1_out_valid), .out_ready(d1_out_ready), .s(d1_s), .cout(d1_cout), .ovf(d1_ovf));

   rca_pipe #(.WIDTH(8), .STAGES(8)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
      .a(d8_a), .b(d8_b), .cin(d8_cin), .sub(d8_sub),
      .out_valid(d8_out_valid), .out_ready(d8_out_ready), .s(d8_s), .cout(d8_cout), .ovf(d8_ovf));

   // {ovf, cout, s}; overflow judged from operand/result signs
   function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic sb);
      logic [15:0] be;
      logic [16:0] full;
      logic        v;
      be   = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, be} + {16'd0, (sb ? 1'b1 : ci)};
      v    = (x[15] == be[15]) && (full[15] != x[15]);
      return {v, full[16], full[15:0]};
   endfunction

   function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic sb);
      logic [7:0] be;
      logic [8:0] full;
      logic       v;
      be   = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, be} + {8'd0, (sb ? 1'b1 : ci)};
      v    = (x[7] == be[7]) && (full[7] != x[7]);
      return {v, full[8], full[7:0]};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", m_out_valid); end
      n_cmp++; if (m_s !== 16'h0000) begin n_err++; $display("FAIL reset_s: got %h expected 0000", m_s); end
      n_cmp++; if (m_cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", m_cout); end
      n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", m_ovf); end
      n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", m_in_ready); end
   endtask

   task automatic test_add_carry();
      int lat;
      @(negedge clk);
      m_out_ready = 1'b1;
      m_in_valid = 1'b1; m_a = 16'hFFFF; m_b = 16'h0001; m_cin = 1'b0; m_sub = 1'b0;
      @(negedge clk);
      m_in_valid = 1'b0;
      lat = 1;
      while (m_out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d expected 4", lat); end
      n_cmp++; if (m_s !== 16'h0000) begin n_err++; $display("FAIL add_s: got %h expected 0000", m_s); end
      n_cmp++; if (m_cout !== 1'b1) begin n_err++; $display("FAIL add_cout: got %b expected 1", m_cout); end
      n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL add_ovf: got %b expected 0", m_ovf); end
   endtask

   task automatic test_subtract();
      int lat;
      @(negedge clk);
      m_out_ready = 1'b1;
      m_in_valid = 1'b1; m_a = 16'h8000; m_b = 16'h0001; m_cin = 1'b1; m_sub = 1'b1;
      @(negedge clk);
      m_a = 16'h0003; m_b = 16'h0005; m_cin = 1'b0; m_sub = 1'b1;
      @(negedge clk);
      m_in_valid = 1'b0;
      lat = 0;
      while (m_out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++; if ({m_ovf, m_cout, m_s} !== {1'b1, 1'b1, 16'h7FFF})
         begin n_err++; $display("FAIL sub_8000_1: got ovf=%b cout=%b s=%h expected ovf=1 cout=1 s=7fff", m_ovf, m_cout, m_s); end
      @(negedge clk);
      n_cmp++; if ({m_out_valid, m_ovf, m_cout, m_s} !== {1'b1, 1'b0, 1'b0, 16'hFFFE})
         begin n_err++; $display("FAIL sub_3_5: got v=%b ovf=%b cout=%b s=%h expected v=1 ovf=0 cout=0 s=fffe", m_out_valid, m_ovf, m_cout, m_s); end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int sent = 0, recv = 0, first_t = -1, last_t = -1;
      logic [17:0] e;
      exp_q.delete();
      for (int t = 0; t < 130; t++) begin
         @(negedge clk);
         m_out_ready = 1'b1;
         if (sent < 100) begin
            m_in_valid = 1'b1;
            m_a = 16'($urandom); m_b = 16'($urandom);
            m_cin = 1'($urandom); m_sub = 1'($urandom);
         end else begin
            m_in_valid = 1'b0;
         end
         #1;
         if (m_in_valid) begin
            n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready t=%0d: got %b expected 1", t, m_in_ready); end
         end
         if (m_out_valid) begin
            if (first_t < 0) first_t = t;
            last_t = t;
            recv++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL b2b_extra t=%0d: got s=%h expected no result", t, m_s);
            end else begin
               e = exp_q.pop_front();
               if ({m_ovf, m_cout, m_s} !== e) begin n_err++; $display("FAIL b2b_result t=%0d: got %h expected %h", t, {m_ovf, m_cout, m_s}, e); end
            end
         end
         if (m_in_valid && m_in_ready) begin
            exp_q.push_back(ref16(m_a, m_b, m_cin, m_sub));
            sent++;
         end
      end
      n_cmp++; if (first_t !== 4) begin n_err++; $display("FAIL b2b_first_cycle: got %0d expected 4", first_t); end
      n_cmp++; if (recv !== 100) begin n_err++; $display("FAIL b2b_count: got %0d expected 100", recv); end
      n_cmp++; if (last_t - first_t !== 99) begin n_err++; $display("FAIL b2b_contiguous: got span %0d expected 99", last_t - first_t); end
   endtask

   task automatic test_backpressure();
      int sent = 0, recv = 0;
      logic pend = 1'b0;
      logic [18:0] snap;
      logic [17:0] e;
      exp_q.delete();
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         m_out_ready = !(t >= 6 && t < 11);
         if (!pend && sent < 12) begin
            m_a = 16'($urandom); m_b = 16'($urandom);
            m_cin = 1'($urandom); m_sub = 1'($urandom);
            pend = 1'b1;
         end
         m_in_valid = pend;
         #1;
         if (t == 6) begin
            snap = {m_out_valid, m_ovf, m_cout, m_s};
            n_cmp++; if (m_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_full: got out_valid=%b expected 1", m_out_valid); end
         end
         if (t >= 6 && t < 11) begin
            n_cmp++; if (m_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready t=%0d: got %b expected 0", t, m_in_ready); end
         end
         if (t >= 7 && t < 11) begin
            n_cmp++; if ({m_out_valid, m_ovf, m_cout, m_s} !== snap)
               begin n_err++; $display("FAIL bp_frozen t=%0d: got %h expected %h", t, {m_out_valid, m_ovf, m_cout, m_s}, snap); end
         end
         if (m_out_valid && m_out_ready) begin
            recv++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL bp_extra t=%0d: got s=%h expected no result", t, m_s);
            end else begin
               e = exp_q.pop_front();
               if ({m_ovf, m_cout, m_s} !== e) begin n_err++; $display("FAIL bp_result t=%0d: got %h expected %h", t, {m_ovf, m_cout, m_s}, e); end
            end
         end
         if (pend && m_in_ready) begin
            exp_q.push_back(ref16(m_a, m_b, m_cin, m_sub));
            sent++;
            pend = 1'b0;
         end
      end
      m_in_valid = 1'b0;
      n_cmp++; if (recv !== 12) begin n_err++; $display("FAIL bp_count: got %0d expected 12", recv); end
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL bp_leftover: got %0d expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      int stale = 0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         m_out_ready = 1'b1;
         m_in_valid = 1'b1;
         m_a = 16'($urandom) | 16'h0001; m_b = 16'($urandom); m_cin = 1'b1; m_sub = 1'b0;
      end
      @(negedge clk);
      m_in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b expected 0", m_out_valid); end
      n_cmp++; if ({m_ovf, m_cout, m_s} !== 18'h0) begin n_err++; $display("FAIL rstmid_data: got %h expected 0", {m_ovf, m_cout, m_s}); end
      n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", m_in_ready); end
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         #1;
         if (m_out_valid) stale++;
      end
      n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rstmid_stale: got %0d beats expected 0", stale); end
   endtask

   task automatic test_stages1();
      @(negedge clk);
      d1_out_ready = 1'b1;
      d1_in_valid = 1'b1; d1_a = 8'h7F; d1_b = 8'h01; d1_cin = 1'b0; d1_sub = 1'b0;
      @(negedge clk);
      d1_in_valid = 1'b0;
      n_cmp++; if ({d1_out_valid, d1_ovf, d1_cout, d1_s} !== {1'b1, 1'b1, 1'b0, 8'h80})
         begin n_err++; $display("FAIL s1_result: got v=%b ovf=%b cout=%b s=%h expected v=1 ovf=1 cout=0 s=80", d1_out_valid, d1_ovf, d1_cout, d1_s); end
      @(negedge clk);
      n_cmp++; if (d1_out_valid !== 1'b0) begin n_err++; $display("FAIL s1_bubble: got %b expected 0", d1_out_valid); end
   endtask

   task automatic test_stages8();
      int sent = 0, recv = 0;
      logic pend = 1'b0;
      logic [9:0] e;
      exp8_q.delete();
      for (int t = 0; t < 3000 && recv < 256; t++) begin
         @(negedge clk);
         d8_out_ready = ($urandom_range(0, 3) != 0);
         if (!pend && sent < 256 && $urandom_range(0, 4) != 0) begin
            d8_a = 8'($urandom); d8_b = 8'($urandom);
            d8_cin = 1'($urandom); d8_sub = 1'($urandom);
            pend = 1'b1;
         end
         d8_in_valid = pend;
         #1;
         if (d8_out_valid && d8_out_ready) begin
            recv++;
            n_cmp++;
            if (exp8_q.size() == 0) begin
               n_err++; $display("FAIL s8_extra t=%0d: got s=%h expected no result", t, d8_s);
            end else begin
               e = exp8_q.pop_front();
               if ({d8_ovf, d8_cout, d8_s} !== e) begin n_err++; $display("FAIL s8_result t=%0d: got %h expected %h", t, {d8_ovf, d8_cout, d8_s}, e); end
            end
         end
         if (pend && d8_in_ready) begin
            exp8_q.push_back(ref8(d8_a, d8_b, d8_cin, d8_sub));
            sent++;
            pend = 1'b0;
         end
      end
      d8_in_valid = 1'b0;
      n_cmp++; if (recv !== 256) begin n_err++; $display("FAIL s8_count: got %0d expected 256", recv); end
   endtask

   initial begin
      rst = 1'b1;
      m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b0;
      d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_sub = 1'b0; d1_out_ready = 1'b1;
      d8_in_valid = 1'b0; d8_a = '0; d8_b = '0; d8_cin = 1'b0; d8_sub = 1'b0; d8_out_ready = 1'b1;
      test_reset();
      test_add_carry();
      test_subtract();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_stages1();
      test_stages8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
